// File: rtl/radar_frame_rx.sv
// Receive-side parser for radar link frames: 55 5A LEN CMD [PAYLOAD] CHK.
// Good frames are published on FrameValid; discarded frames report a cause on ErrValid/ErrCode.
module radar_frame_rx #(
    parameter int MAX_PAYLOAD = 8,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic                     Clk,
    input  logic                     RstN,
    input  logic                     RxValid,
    input  logic [7:0]               RxData,
    output logic                     FrameValid,
    output logic [7:0]               FrameCmd,
    output logic [7:0]               FrameLen,
    output logic [8*MAX_PAYLOAD-1:0] FrameData,
    output logic                     ErrValid,
    output logic [1:0]               ErrCode
);

    localparam int IDX_W = $clog2(MAX_PAYLOAD) + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] LEN_MIN = 8'd2;
    localparam logic [7:0] LEN_MAX = 8'(MAX_PAYLOAD + 2);

    localparam logic [2:0] S_HDR1 = 3'd0;
    localparam logic [2:0] S_HDR2 = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_CMD  = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_CHK  = 3'd5;

    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    logic [2:0]       state_q,       state_d;
    logic [7:0]       sum_q,         sum_d;
    logic [7:0]       remaining_q,   remaining_d;
    logic [IDX_W-1:0] idx_q,         idx_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [7:0]       shadow_cmd_q,  shadow_cmd_d;
    logic [7:0]       shadow_len_q,  shadow_len_d;
    logic [7:0]       shadow_data_q [MAX_PAYLOAD];
    logic [7:0]       shadow_data_d [MAX_PAYLOAD];
    logic             frame_valid_q, frame_valid_d;
    logic [7:0]       frame_cmd_q,   frame_cmd_d;
    logic [7:0]       frame_len_q,   frame_len_d;
    logic [7:0]       frame_data_q  [MAX_PAYLOAD];
    logic [7:0]       frame_data_d  [MAX_PAYLOAD];
    logic             err_valid_q,   err_valid_d;
    logic [1:0]       err_code_q,    err_code_d;

    logic                   timeout_hit;
    logic                   byte_ok;
    logic                   shadow_clear;
    logic [MAX_PAYLOAD-1:0] lane_we;

    // A byte landing on the timeout cycle is dropped: the timeout takes priority.
    assign timeout_hit  = (state_q != S_HDR1) && (cnt_q == CNT_LAST);
    assign byte_ok      = RxValid && !timeout_hit;
    assign shadow_clear = byte_ok && (state_q == S_HDR2) && (RxData == 8'h5A);

    assign cnt_d = (RxValid || timeout_hit || state_q == S_HDR1) ? '0 : cnt_q + CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_lane
            assign lane_we[gi] = byte_ok && (state_q == S_DATA) && (idx_q == IDX_W'(gi));
            assign shadow_data_d[gi] = shadow_clear ? 8'h00 :
                                       lane_we[gi]  ? RxData : shadow_data_q[gi];
            assign FrameData[gi*8 +: 8] = frame_data_q[gi];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        remaining_d   = remaining_q;
        idx_d         = idx_q;
        shadow_cmd_d  = shadow_cmd_q;
        shadow_len_d  = shadow_len_q;
        frame_valid_d = 1'b0;
        frame_cmd_d   = frame_cmd_q;
        frame_len_d   = frame_len_q;
        frame_data_d  = frame_data_q;
        err_valid_d   = 1'b0;
        err_code_d    = err_code_q;

        if (timeout_hit) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = S_HDR1;
        end else if (RxValid) begin
            case (state_q)
                S_HDR1: begin
                    if (RxData == 8'h55) state_d = S_HDR2;
                end
                S_HDR2: begin
                    if (RxData == 8'h5A)      state_d = S_LEN;
                    else if (RxData != 8'h55) state_d = S_HDR1;
                end
                S_LEN: begin
                    if (RxData >= LEN_MIN && RxData <= LEN_MAX) begin
                        // 55 + 5A folds to AF, so the running sum starts there.
                        state_d      = S_CMD;
                        remaining_d  = RxData - 8'd1;
                        sum_d        = 8'hAF + RxData;
                        idx_d        = '0;
                        shadow_len_d = RxData - 8'd2;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = S_HDR1;
                    end
                end
                S_CMD: begin
                    shadow_cmd_d = RxData;
                    sum_d        = sum_q + RxData;
                    remaining_d  = remaining_q - 8'd1;
                    state_d      = (remaining_q == 8'd1) ? S_CHK : S_DATA;
                end
                S_DATA: begin
                    idx_d       = idx_q + IDX_W'(1);
                    sum_d       = sum_q + RxData;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) state_d = S_CHK;
                end
                S_CHK: begin
                    if (RxData == sum_q) begin
                        frame_valid_d = 1'b1;
                        frame_cmd_d   = shadow_cmd_q;
                        frame_len_d   = shadow_len_q;
                        frame_data_d  = shadow_data_q;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                    state_d = S_HDR1;
                end
                default: state_d = S_HDR1;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q       <= S_HDR1;
            sum_q         <= '0;
            remaining_q   <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            shadow_cmd_q  <= '0;
            shadow_len_q  <= '0;
            shadow_data_q <= '{default: 8'h00};
            frame_valid_q <= 1'b0;
            frame_cmd_q   <= '0;
            frame_len_q   <= '0;
            frame_data_q  <= '{default: 8'h00};
            err_valid_q   <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            remaining_q   <= remaining_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            shadow_cmd_q  <= shadow_cmd_d;
            shadow_len_q  <= shadow_len_d;
            shadow_data_q <= shadow_data_d;
            frame_valid_q <= frame_valid_d;
            frame_cmd_q   <= frame_cmd_d;
            frame_len_q   <= frame_len_d;
            frame_data_q  <= frame_data_d;
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
        end
    end

    assign FrameValid = frame_valid_q;
    assign FrameCmd   = frame_cmd_q;
    assign FrameLen   = frame_len_q;
    assign ErrValid   = err_valid_q;
    assign ErrCode    = err_code_q;

endmodule

// File: tb/tb_radar_frame_rx.sv
// Directed scoreboard bench for radar_frame_rx: expected frames/errors are queued as bytes
// are driven and compared when the DUT pulses FrameValid or ErrValid.
module tb_radar_frame_rx;

    localparam int MAXP = 8;
    localparam int TOUT = 40;

    logic            Clk = 1'b0;
    logic            RstN = 1'b0;
    logic            RxValid = 1'b0;
    logic [7:0]      RxData = 8'h00;
    logic            FrameValid;
    logic [7:0]      FrameCmd;
    logic [7:0]      FrameLen;
    logic [8*MAXP-1:0] FrameData;
    logic            ErrValid;
    logic [1:0]      ErrCode;

    typedef struct {
        bit          is_frame;
        logic [7:0]  cmd;
        logic [7:0]  len;
        logic [63:0] data;
        logic [1:0]  code;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_pulse  = 0;

    radar_frame_rx #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYC(TOUT)) dut (
        .Clk(Clk), .RstN(RstN), .RxValid(RxValid), .RxData(RxData),
        .FrameValid(FrameValid), .FrameCmd(FrameCmd), .FrameLen(FrameLen),
        .FrameData(FrameData), .ErrValid(ErrValid), .ErrCode(ErrCode)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input int id, input logic [7:0] cmd, input logic [7:0] len,
                              input logic [63:0] data);
        exp_t e;
        e.is_frame = 1'b1; e.cmd = cmd; e.len = len; e.data = data; e.code = 2'd0; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input int id, input logic [1:0] code);
        exp_t e;
        e.is_frame = 1'b0; e.cmd = 8'h00; e.len = 8'h00; e.data = 64'h0; e.code = code; e.id = id;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; byte is sampled on the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        RxValid = 1'b1;
        RxData  = b;
        @(negedge Clk);
        RxValid = 1'b0;
    endtask

    // Builds a complete frame, computes its checksum locally, and queues the expected outcome.
    task automatic send_frame(input int id, input logic [7:0] cmd, input int n,
                              input logic [63:0] pl, input bit bad);
        logic [7:0]  s;
        logic [7:0]  b;
        logic [63:0] masked;
        s = 8'h55 + 8'h5A + 8'(n + 2) + cmd;
        masked = 64'h0;
        for (int i = 0; i < n; i++) begin
            b = pl[i*8 +: 8];
            s = s + b;
            masked[i*8 +: 8] = b;
        end
        if (bad) push_err(id, 2'd1);
        else     push_frame(id, cmd, 8'(n), masked);
        send_byte(8'h55);
        send_byte(8'h5A);
        send_byte(8'(n + 2));
        send_byte(cmd);
        for (int i = 0; i < n; i++) send_byte(pl[i*8 +: 8]);
        send_byte(bad ? s + 8'd1 : s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < TOUT + 50) begin
            @(negedge Clk);
            k++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge Clk) begin
        if (RstN) begin
            if (FrameValid || ErrValid) begin
                chk("exclusive_pulse", 64'(FrameValid && ErrValid), 64'd0);
                n_pulse++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, FrameValid, ErrValid}, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("kind_%0d", e.id), 64'(FrameValid), 64'(e.is_frame));
                    if (e.is_frame) begin
                        chk($sformatf("cmd_%0d", e.id),  64'(FrameCmd), 64'(e.cmd));
                        chk($sformatf("len_%0d", e.id),  64'(FrameLen), 64'(e.len));
                        chk($sformatf("data_%0d", e.id), FrameData, e.data);
                    end else begin
                        chk($sformatf("code_%0d", e.id), 64'(ErrCode), 64'(e.code));
                    end
                    $display("txn %0d: frame=%0b err=%0b cmd=%h len=%0d data=%h code=%0d",
                             e.id, FrameValid, ErrValid, FrameCmd, FrameLen, FrameData, ErrCode);
                end
            end
        end
    end

    initial begin
        int lat;
        int pulses_before;

        // Reset state
        idle(3);
        chk("rst_fv", 64'(FrameValid), 64'd0);
        chk("rst_ev", 64'(ErrValid), 64'd0);
        chk("rst_cmd", 64'(FrameCmd), 64'd0);
        chk("rst_len", 64'(FrameLen), 64'd0);
        chk("rst_data", FrameData, 64'd0);
        chk("rst_code", 64'(ErrCode), 64'd0);
        RstN = 1'b1;
        idle(2);

        // T1: minimal frame
        push_frame(1, 8'hD3, 8'd0, 64'h0);
        send_byte(8'h55); send_byte(8'h5A); send_byte(8'h02); send_byte(8'hD3); send_byte(8'h84);
        idle(2);

        // T2: one payload byte
        push_frame(2, 8'hD1, 8'd1, 64'h01);
        send_byte(8'h55); send_byte(8'h5A); send_byte(8'h03); send_byte(8'hD1);
        send_byte(8'h01); send_byte(8'h84);
        idle(2);

        // T3: bad checksum leaves the published frame untouched
        push_err(3, 2'd1);
        send_byte(8'h55); send_byte(8'h5A); send_byte(8'h02); send_byte(8'hD3); send_byte(8'h85);
        idle(3);
        chk("t3_cmd_held", 64'(FrameCmd), 64'hD1);
        chk("t3_len_held", 64'(FrameLen), 64'd1);
        chk("t3_data_held", FrameData, 64'h01);
        chk("t3_code_held", 64'(ErrCode), 64'd1);

        // T4: illegal LEN, then an immediate good frame
        push_err(4, 2'd2);
        send_byte(8'h55); send_byte(8'h5A); send_byte(8'h20);
        push_frame(5, 8'hD3, 8'd0, 64'h0);
        send_byte(8'h55); send_byte(8'h5A); send_byte(8'h02); send_byte(8'hD3); send_byte(8'h84);
        idle(2);

        // LEN just outside the legal range on both sides
        push_err(6, 2'd2);
        send_byte(8'h55); send_byte(8'h5A); send_byte(8'h01);
        push_err(7, 2'd2);
        send_byte(8'h55); send_byte(8'h5A); send_byte(8'(MAXP + 3));
        idle(2);

        // T5: resync through junk and a repeated 55
        push_frame(8, 8'hD3, 8'd0, 64'h0);
        send_byte(8'h12); send_byte(8'h55); send_byte(8'h55); send_byte(8'h5A);
        send_byte(8'h02); send_byte(8'hD3); send_byte(8'h84);
        idle(2);

        // Full payload, then a short frame back-to-back: unused bytes must read 0
        send_frame(9, 8'hA7, MAXP, 64'hF1E2D3C4B5A69788, 1'b0);
        send_frame(10, 8'h3C, 2, 64'hFFFFFFFFFFFF5AC3, 1'b0);
        send_frame(11, 8'h99, 5, 64'h0000001122334455, 1'b1);
        idle(2);
        drain("drain_frames");

        // T6: timeout after LEN, with exact idle-cycle latency
        push_err(12, 2'd3);
        send_byte(8'h55); send_byte(8'h5A); send_byte(8'h02);
        lat = 0;
        while (!ErrValid && lat < TOUT + 20) begin
            @(negedge Clk);
            lat++;
        end
        chk("t6_latency", 64'(lat), 64'(TOUT));
        idle(2);

        // Byte arriving on the timeout cycle is dropped
        push_err(13, 2'd3);
        send_byte(8'h55); send_byte(8'h5A); send_byte(8'h02);
        idle(TOUT - 1);
        send_byte(8'hD3);
        send_byte(8'h84);
        idle(3);
        drain("drain_timeout");
        chk("t6_code", 64'(ErrCode), 64'd3);

        // Reset mid-frame: no pulse, everything cleared
        pulses_before = n_pulse;
        send_byte(8'h55); send_byte(8'h5A); send_byte(8'h03); send_byte(8'hD1);
        RstN = 1'b0;
        idle(2);
        chk("rst2_cmd", 64'(FrameCmd), 64'd0);
        chk("rst2_len", 64'(FrameLen), 64'd0);
        chk("rst2_data", FrameData, 64'd0);
        chk("rst2_code", 64'(ErrCode), 64'd0);
        RstN = 1'b1;
        idle(1);
        send_byte(8'h01); send_byte(8'h84);
        idle(TOUT + 5);
        chk("rst2_no_pulse", 64'(n_pulse - pulses_before), 64'd0);

        // Recovery after reset
        send_frame(14, 8'h5E, 3, 64'h0000000000C0FFEE, 1'b0);
        idle(2);
        drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
